dealer_turn_seq: RTL and testbench
==================================

Name: dealer_turn_seq

Overview:
- Sequential dealer-play stage directly downstream of the combinational dealer draw/valuation block.
- Runs after the player stands. Consumes the dealer's two dealt cards and three pre-drawn cards (card1..card5).
- Reveals cards one at a time with a visible delay, applies the stand-on-17 rule with soft-ace handling, then resolves the round against the player total.
- Drives the display and outcome logic.

Parameters:
- REVEAL_DELAY, 25000000: clock cycles between successive dealer card reveals (0.5 s at 50 MHz); minimum 1.
- CNT_W, 25: width of the delay counter; must satisfy 2^CNT_W > REVEAL_DELAY.
- STAND_VALUE, 17: the dealer stands when the best total is greater than or equal to this value.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: player has stood (or busted); begin dealer turn.
- card1..card5  input  8 each  dealer card ranks; 1=ace, 2-10 pip, 11-13 face.
- player_value  input  8  player's final best total.
- player_bust  input  1  player total exceeds 21.
- shown_count  output  3  number of dealer cards currently revealed (0, 2..5).
- dealer_total  output  8  best total of the revealed cards.
- dealer_bust  output  1  dealer_total > 21.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  high while in DONE; result is valid.
- result  output  2  00 none, 01 player wins, 10 dealer wins, 11 push.

Behaviour:
- One clock domain; reset is synchronous and active-high. rst dominates start.
- Reset values: state IDLE; shown_count 0; dealer_total 0; dealer_bust 0; busy 0; done 0; result 00; counter 0.
- Reset asserted in any state, including mid-WAIT, returns to these values on the next edge.
- Card points: rank 1 = 1 point and marks an ace; 2-10 = rank; 11-13 = 10; rank 0 or >13 = 10.
- hard = sum of the points of the first shown_count cards, 8-bit, no overflow possible.
- dealer_total = hard+10 if any revealed ace and hard+10 <= 21; otherwise hard.
- All outputs are registered.
- States: IDLE, REVEAL, DECIDE, WAIT, COMPARE, DONE.
- IDLE / DONE:
  - start=1 latches card1..card5, player_value and player_bust.
  - Clears result and done; go to REVEAL.
  - start is ignored in all other states.
- REVEAL (1 cycle): shown_count <= 2; busy=1; go to DECIDE.
- DECIDE (1 cycle): evaluate with the current shown_count.
  - Go to COMPARE if any of: latched player_bust; dealer_total >= STAND_VALUE; shown_count == 5.
  - Otherwise load counter = REVEAL_DELAY-1 and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter is 0: shown_count++, go to DECIDE.
  - Exactly REVEAL_DELAY cycles are spent in WAIT per added card.
- COMPARE (1 cycle): result rules, in priority order:
  - player_bust -> 10.
  - dealer_bust -> 01.
  - player_value > dealer_total -> 01.
  - player_value < dealer_total -> 10.
  - equal -> 11.
  - Go to DONE.
- DONE: busy=0, done=1; result, shown_count and dealer_total hold until the next start or reset.
- Latency with no draws: start at edge 0 -> done at edge 4.
  - REVEAL at edge 1, DECIDE at edge 2, COMPARE at edge 3.
  - Each drawn card adds REVEAL_DELAY+1 cycles.
- Five-card cap: after the 5th card the dealer stops regardless of total.
- A start pulse held for multiple cycles is accepted once; the subsequent high cycles fall in non-IDLE states and are ignored.

Test Plan:
- REVEAL_DELAY=4 for all scenarios.
- Cards 10,7; player 18 -> shown_count 2, dealer_total 17, no WAIT, done 4 cycles after start, result 01.
- Cards 5,6,10; player 20 -> one WAIT of 4 cycles, shown_count 3, dealer_total 21, result 10, done 9 cycles after start.
- Cards 1,6 (soft 17); player 17 -> dealer stands, dealer_total 17, result 11. Cards 1,5,10 -> dealer draws; hard 16 = dealer_total 16, ace stays low.
- Cards 10,6,9; player 19 -> dealer_total 25, dealer_bust 1, result 01.
- Cards 2,3,2,3,2; player 13 -> shown_count 5, dealer_total 12, stops at cap, result 01.
- player_bust=1, cards 2,3 -> shown_count 2, result 10.
- rst asserted mid-WAIT -> all outputs 0 on the next edge.
- start while busy -> ignored; no change to latched cards.

Source files
------------

// File: rtl/dealer_turn_seq.sv
// Dealer turn sequencer: reveals dealer cards one at a time, applies stand-on-STAND_VALUE
// with soft-ace promotion, and resolves the round against the latched player total.
module dealer_turn_seq #(
    parameter int REVEAL_DELAY = 25000000,
    parameter int CNT_W        = 25,
    parameter int STAND_VALUE  = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] card1,
    input  logic [7:0] card2,
    input  logic [7:0] card3,
    input  logic [7:0] card4,
    input  logic [7:0] card5,
    input  logic [7:0] player_value,
    input  logic       player_bust,
    output logic [2:0] shown_count,
    output logic [7:0] dealer_total,
    output logic       dealer_bust,
    output logic       busy,
    output logic       done,
    output logic [1:0] result
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REVEAL  = 3'd1;
    localparam logic [2:0] ST_DECIDE  = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_COMPARE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REVEAL_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       STAND_TOTAL = 8'(STAND_VALUE);

    logic [2:0]       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [39:0]      cards_r, cards_s;
    logic [7:0]       pv_r, pv_s;
    logic             pb_r, pb_s;
    logic [2:0]       shown_s;
    logic [7:0]       total_s;
    logic             bust_s;
    logic             busy_s;
    logic             done_s;
    logic [1:0]       result_s;

    function automatic logic [7:0] card_points(input logic [7:0] rank);
        logic [7:0] pts;
        if ((rank >= 8'd1) && (rank <= 8'd10)) begin
            pts = rank;
        end else begin
            pts = 8'd10;
        end
        return pts;
    endfunction

    // Aces count low in the hard sum; one ace is promoted to 11 when that cannot bust.
    function automatic logic [7:0] best_total(input logic [2:0] cnt, input logic [39:0] cards);
        logic [7:0] hard;
        logic       ace;
        logic [7:0] res;
        hard = 8'd0;
        ace  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (3'(i) < cnt) begin
                hard = hard + card_points(cards[8*i +: 8]);
                if (cards[8*i +: 8] == 8'd1) begin
                    ace = 1'b1;
                end else begin
                    ace = ace;
                end
            end else begin
                hard = hard;
            end
        end
        if (ace && ((hard + 8'd10) <= 8'd21)) begin
            res = hard + 8'd10;
        end else begin
            res = hard;
        end
        return res;
    endfunction

    // Next-state and next-output logic for the dealer sequencer.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        cards_s  = cards_r;
        pv_s     = pv_r;
        pb_s     = pb_r;
        shown_s  = shown_count;
        total_s  = dealer_total;
        bust_s   = dealer_bust;
        busy_s   = busy;
        done_s   = done;
        result_s = result;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cards_s  = {card5, card4, card3, card2, card1};
                    pv_s     = player_value;
                    pb_s     = player_bust;
                    result_s = 2'b00;
                    done_s   = 1'b0;
                    busy_s   = 1'b1;
                    state_s  = ST_REVEAL;
                end else begin
                    state_s = state_r;
                end
            end
            ST_REVEAL: begin
                shown_s = 3'd2;
                total_s = best_total(3'd2, cards_r);
                bust_s  = (total_s > 8'd21);
                busy_s  = 1'b1;
                state_s = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (pb_r || (dealer_total >= STAND_TOTAL) || (shown_count == 3'd5)) begin
                    state_s = ST_COMPARE;
                end else begin
                    cnt_s   = DELAY_LOAD;
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    shown_s = shown_count + 3'd1;
                    total_s = best_total(shown_s, cards_r);
                    bust_s  = (total_s > 8'd21);
                    state_s = ST_DECIDE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_COMPARE: begin
                if (pb_r) begin
                    result_s = 2'b10;
                end else if (dealer_bust) begin
                    result_s = 2'b01;
                end else if (pv_r > dealer_total) begin
                    result_s = 2'b01;
                end else if (pv_r < dealer_total) begin
                    result_s = 2'b10;
                end else begin
                    result_s = 2'b11;
                end
                busy_s  = 1'b0;
                done_s  = 1'b1;
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; rst has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            cards_r      <= 40'd0;
            pv_r         <= 8'd0;
            pb_r         <= 1'b0;
            shown_count  <= 3'd0;
            dealer_total <= 8'd0;
            dealer_bust  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= 2'b00;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            cards_r      <= cards_s;
            pv_r         <= pv_s;
            pb_r         <= pb_s;
            shown_count  <= shown_s;
            dealer_total <= total_s;
            dealer_bust  <= bust_s;
            busy         <= busy_s;
            done         <= done_s;
            result       <= result_s;
        end
    end

endmodule

// File: tb/tb_dealer_turn_seq.sv
// Directed bench for dealer_turn_seq with REVEAL_DELAY=4; expected values are hand-computed.
module tb_dealer_turn_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] card1, card2, card3, card4, card5;
    logic [7:0] player_value;
    logic       player_bust;
    logic [2:0] shown_count;
    logic [7:0] dealer_total;
    logic       dealer_bust;
    logic       busy;
    logic       done;
    logic [1:0] result;

    int checks = 0;
    int errors = 0;
    int lat;

    dealer_turn_seq #(.REVEAL_DELAY(4), .CNT_W(8), .STAND_VALUE(17)) dut (
        .clk(clk), .rst(rst), .start(start),
        .card1(card1), .card2(card2), .card3(card3), .card4(card4), .card5(card5),
        .player_value(player_value), .player_bust(player_bust),
        .shown_count(shown_count), .dealer_total(dealer_total), .dealer_bust(dealer_bust),
        .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [7:0] c1, c2, c3, c4, c5, input logic [7:0] pv, input logic pb);
        card1 = c1; card2 = c2; card3 = c3; card4 = c4; card5 = c5;
        player_value = pv; player_bust = pb;
    endtask

    // One-cycle start; returns just after the edge that samples it (cycle count 1).
    task automatic pulse_start(input logic [7:0] c1, c2, c3, c4, c5, input logic [7:0] pv, input logic pb);
        @(posedge clk); #1;
        set_in(c1, c2, c3, c4, c5, pv, pb);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int n);
        n = from;
        while ((done !== 1'b1) && (n < 200)) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_final(input string tag, input int exp_lat, input int exp_shown,
                               input int exp_total, input logic exp_bust, input logic [1:0] exp_res);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_shown"}, 32'(shown_count), exp_shown);
        check({tag, "_total"}, 32'(dealer_total), exp_total);
        check({tag, "_bust"}, 32'(dealer_bust), 32'(exp_bust));
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        set_in(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_shown", 32'(shown_count), 32'd0);
        check("reset_total", 32'(dealer_total), 32'd0);
        check("reset_flags", {28'd0, dealer_bust, busy, done, 1'b0}, 32'd0);
        check("reset_result", 32'(result), 32'd0);
        rst = 1'b0;

        // 10,7 stands at 17; player 18 wins
        pulse_start(8'd10, 8'd7, 8'd2, 8'd2, 8'd2, 8'd18, 1'b0);
        check("s1_busy_early", 32'(busy), 32'd1);
        wait_done(1, lat);
        check_final("s1", 4, 2, 17, 1'b0, 2'b01);

        // 5,6 -> draw 10 = 21; player 20 loses
        pulse_start(8'd5, 8'd6, 8'd10, 8'd2, 8'd2, 8'd20, 1'b0);
        check("s2_done_cleared", 32'(done), 32'd0);
        wait_done(1, lat);
        check_final("s2", 9, 3, 21, 1'b0, 2'b10);

        // soft 17 stands; push
        pulse_start(8'd1, 8'd6, 8'd10, 8'd2, 8'd2, 8'd17, 1'b0);
        wait_done(1, lat);
        check_final("s3", 4, 2, 17, 1'b0, 2'b11);

        // soft 16 draws a 10: ace drops to low, 16, then a 5 -> 21
        pulse_start(8'd1, 8'd5, 8'd10, 8'd5, 8'd2, 8'd20, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("s4_mid_shown", 32'(shown_count), 32'd3);
        check("s4_mid_total", 32'(dealer_total), 32'd16);
        check("s4_mid_busy", 32'(busy), 32'd1);
        wait_done(7, lat);
        check_final("s4", 14, 4, 21, 1'b0, 2'b10);

        // dealer busts at 25
        pulse_start(8'd10, 8'd6, 8'd9, 8'd2, 8'd2, 8'd19, 1'b0);
        wait_done(1, lat);
        check_final("s5", 9, 3, 25, 1'b1, 2'b01);

        // five-card cap at 12
        pulse_start(8'd2, 8'd3, 8'd2, 8'd3, 8'd2, 8'd13, 1'b0);
        wait_done(1, lat);
        check_final("s6", 19, 5, 12, 1'b0, 2'b01);

        // player busted: no draws, dealer wins
        pulse_start(8'd2, 8'd3, 8'd10, 8'd10, 8'd10, 8'd25, 1'b1);
        wait_done(1, lat);
        check_final("s7", 4, 2, 5, 1'b0, 2'b10);

        // reset in the middle of WAIT
        pulse_start(8'd5, 8'd6, 8'd10, 8'd2, 8'd2, 8'd20, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("s8_busy_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("s8_rst_shown", 32'(shown_count), 32'd0);
        check("s8_rst_total", 32'(dealer_total), 32'd0);
        check("s8_rst_flags", {28'd0, dealer_bust, busy, done, 1'b0}, 32'd0);
        check("s8_rst_result", 32'(result), 32'd0);

        // start held two cycles, then re-pulsed mid-WAIT with other cards: both ignored
        @(posedge clk); #1;
        set_in(8'd5, 8'd6, 8'd10, 8'd2, 8'd2, 8'd20, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        check("s9_busy", 32'(busy), 32'd1);
        set_in(8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd21, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(5, lat);
        check_final("s9", 9, 3, 21, 1'b0, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
